// File: rtl/display_page_scheduler.sv
// display_page_scheduler: steps a 7-seg halfword display through N_WORDS monitor words,
// two pages per word, advanced by a debounced key (MANUAL) or a fixed period (AUTO).
`default_nettype none

module display_page_scheduler #(
  parameter int N_WORDS         = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_CYCLES     = 50000000,
  localparam int IDXW = ($clog2(N_WORDS) > 0) ? $clog2(N_WORDS) : 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  key_step_n,
  input  logic                  key_mode_n,
  input  logic                  freeze,
  input  logic [N_WORDS*32-1:0] words_in,
  output logic [31:0]           word_out,
  output logic                  hl_sw,
  output logic [IDXW-1:0]       word_index,
  output logic                  auto_mode,
  output logic                  page_tick
);

  localparam int NPAGES = 2 * N_WORDS;
  localparam int PW     = $clog2(NPAGES);
  localparam int DBW    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int ATW    = $clog2(AUTO_CYCLES);

  localparam logic [DBW-1:0] DB_LAST   = DBW'(DEBOUNCE_CYCLES - 1);
  localparam logic [ATW-1:0] AUTO_LAST = ATW'(AUTO_CYCLES - 1);
  localparam logic [PW-1:0]  PAGE_LAST = PW'(NPAGES - 1);

  typedef enum logic {
    MANUAL = 1'b0,
    AUTO   = 1'b1
  } mode_e;

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_q;
  logic       rst_n_int;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_q <= 2'b00;
    else          rst_q <= {rst_q[0], 1'b1};
  end

  assign rst_n_int = rst_q[1];

  logic [1:0] key_raw;
  logic [1:0] key_evt;

  assign key_raw = {key_mode_n, key_step_n};

  for (genvar g = 0; g < 2; g++) begin : g_key
    logic [1:0]     sync;
    logic           level;
    logic [DBW-1:0] cnt;
    logic           evt;

    always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
        sync  <= 2'b11;
        level <= 1'b1;
        cnt   <= '0;
        evt   <= 1'b0;
      end else begin
        sync <= {sync[0], key_raw[g]};
        evt  <= 1'b0;
        if (sync[1] == level) begin
          cnt <= '0;
        end else if (cnt == DB_LAST) begin
          level <= sync[1];
          cnt   <= '0;
          evt   <= ~sync[1];
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end

    assign key_evt[g] = evt;
  end

  logic step_evt;
  logic mode_evt;

  assign step_evt = key_evt[0];
  assign mode_evt = key_evt[1];

  mode_e          state;
  mode_e          state_nx;
  logic [ATW-1:0] tick_cnt;
  logic [ATW-1:0] tick_nx;
  logic [PW-1:0]  page;
  logic [PW-1:0]  page_nx;
  logic           advance;

  // A mode event takes priority; a step in the terminal cycle still advances only once.
  always_comb begin
    state_nx = state;
    tick_nx  = tick_cnt;
    advance  = 1'b0;
    case (state)
      MANUAL: begin
        tick_nx = '0;
        if (mode_evt)      state_nx = AUTO;
        else if (step_evt) advance  = 1'b1;
      end
      AUTO: begin
        if (mode_evt) begin
          state_nx = MANUAL;
          tick_nx  = '0;
        end else if (step_evt || (tick_cnt == AUTO_LAST)) begin
          advance = 1'b1;
          tick_nx = '0;
        end else begin
          tick_nx = tick_cnt + 1'b1;
        end
      end
      default: state_nx = MANUAL;
    endcase
  end

  assign page_nx = !advance ? page : ((page == PAGE_LAST) ? '0 : page + 1'b1);

  logic [IDXW-1:0] next_idx;
  logic [31:0]     sel_word;

  assign next_idx = IDXW'(page_nx >> 1);
  assign sel_word = words_in[{next_idx, 5'b00000} +: 32];

  // Selecting by the next page keeps word_out coherent with hl_sw/word_index.
  always_ff @(posedge clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state     <= MANUAL;
      tick_cnt  <= '0;
      page      <= '0;
      page_tick <= 1'b0;
      word_out  <= '0;
    end else begin
      state     <= state_nx;
      tick_cnt  <= tick_nx;
      page      <= page_nx;
      page_tick <= advance;
      if (!freeze || advance) word_out <= sel_word;
    end
  end

  assign hl_sw      = page[0];
  assign word_index = IDXW'(page >> 1);
  assign auto_mode  = (state == AUTO);

endmodule

`default_nettype wire

// File: tb/tb_display_page_scheduler.sv
// Self-checking bench for display_page_scheduler: vector table for key conditioning and
// stepping, scoreboard of expected pages popped on page_tick, plus hand-written sequences.
`default_nettype none

module tb_display_page_scheduler;

  localparam int N_WORDS = 3;
  localparam int DEB_C   = 4;
  localparam int AUTO_C  = 10;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        key_step_n;
  logic        key_mode_n;
  logic        freeze;
  logic [31:0] w [3];
  logic [N_WORDS*32-1:0] words_in;
  logic [31:0] word_out;
  logic        hl_sw;
  logic [1:0]  word_index;
  logic        auto_mode;
  logic        page_tick;

  assign words_in = {w[2], w[1], w[0]};

  display_page_scheduler #(
    .N_WORDS        (N_WORDS),
    .DEBOUNCE_CYCLES(DEB_C),
    .AUTO_CYCLES    (AUTO_C)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .key_step_n(key_step_n),
    .key_mode_n(key_mode_n),
    .freeze    (freeze),
    .words_in  (words_in),
    .word_out  (word_out),
    .hl_sw     (hl_sw),
    .word_index(word_index),
    .auto_mode (auto_mode),
    .page_tick (page_tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  idx;
    logic        hl;
    logic [31:0] word;
  } exp_t;

  typedef struct {
    int low;
    bit bounce;
    bit adv;
  } vec_t;

  exp_t exp_q[$];
  int   tick_times[$];
  exp_t mon_e;
  int   vectors     = 0;
  int   miscompares = 0;
  int   page_m      = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_adv();
    page_m = (page_m + 1) % (2 * N_WORDS);
    exp_q.push_back('{idx: 2'(page_m / 2), hl: 1'(page_m % 2), word: w[page_m / 2]});
  endfunction

  always @(negedge clk) begin
    if (reset_n && page_tick) begin
      tick_times.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("unexpected_tick", 64'd1, 64'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("tick_page", {word_index, hl_sw, word_out}, {mon_e.idx, mon_e.hl, mon_e.word});
      end
    end
  end

  task automatic press(input int low, input bit step, input bit mode);
    @(negedge clk);
    key_step_n = ~step;
    key_mode_n = ~mode;
    repeat (low) @(negedge clk);
    key_step_n = 1'b1;
    key_mode_n = 1'b1;
  endtask

  task automatic wait_ticks(input int n, input int budget);
    int b;
    b = budget;
    while (tick_times.size() < n && b > 0) begin
      @(negedge clk);
      #1;
      b--;
    end
    check($sformatf("tick_count_%0d", n), tick_times.size(), n);
  endtask

  initial begin
    vec_t        tbl [8];
    logic [31:0] v;
    logic [31:0] prev;

    tbl[0] = '{low: 2, bounce: 1'b0, adv: 1'b0};
    tbl[1] = '{low: 8, bounce: 1'b0, adv: 1'b1};
    tbl[2] = '{low: 0, bounce: 1'b1, adv: 1'b0};
    for (int i = 3; i < 8; i++) tbl[i] = '{low: 8, bounce: 1'b0, adv: 1'b1};

    reset_n    = 1'b0;
    key_step_n = 1'b1;
    key_mode_n = 1'b1;
    freeze     = 1'b0;
    w[0] = 32'h1111_AAAA;
    w[1] = 32'h2222_BBBB;
    w[2] = 32'h3333_CCCC;
    prev = '0;

    repeat (3) @(negedge clk);
    check("rst_word_out", word_out, 0);
    check("rst_hl_sw", hl_sw, 0);
    check("rst_word_index", word_index, 0);
    check("rst_auto_mode", auto_mode, 0);
    check("rst_page_tick", page_tick, 0);
    reset_n = 1'b1;
    repeat (5) @(negedge clk);

    // Key conditioning and manual stepping through all pages with wrap.
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].adv) push_adv();
      if (tbl[i].bounce) begin
        for (int k = 0; k < 6; k++) begin
          @(negedge clk) key_step_n = 1'b0;
          @(negedge clk) key_step_n = 1'b1;
        end
      end else begin
        press(tbl[i].low, 1'b1, 1'b0);
      end
      repeat (12) @(negedge clk);
      #1;
      check($sformatf("vec%0d_pending", i), exp_q.size(), 0);
      check($sformatf("vec%0d_page", i), {word_index, hl_sw}, {2'(page_m / 2), 1'(page_m % 2)});
    end

    // Live tracking with one-cycle latency.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i > 0) check("follow_live", word_out, prev);
      v    = $urandom;
      w[0] = v;
      prev = v;
    end

    // Freeze holds a snapshot; each page change captures once.
    @(negedge clk);
    w[0]   = 32'h1234_5678;
    freeze = 1'b0;
    repeat (2) @(negedge clk);
    check("pre_freeze", word_out, 32'h1234_5678);
    freeze = 1'b1;
    w[0]   = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    check("frozen_hold", word_out, 32'h1234_5678);
    w[1] = 32'hCAFE_F00D;
    push_adv();
    press(8, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    push_adv();
    press(8, 1'b1, 1'b0);
    repeat (12) @(negedge clk);
    #1;
    check("freeze_pending", exp_q.size(), 0);
    w[1] = 32'h0BAD_0BAD;
    repeat (3) @(negedge clk);
    check("frozen_snapshot", word_out, 32'hCAFE_F00D);
    freeze = 1'b0;
    repeat (2) @(negedge clk);
    check("unfreeze", word_out, 32'h0BAD_0BAD);

    // AUTO: fixed period, nudge restart, mode beats step.
    tick_times.delete();
    push_adv();
    push_adv();
    push_adv();
    press(8, 1'b0, 1'b1);
    wait_ticks(3, 80);
    check("auto_on", auto_mode, 1);
    if (tick_times.size() >= 3) begin
      check("auto_period_a", tick_times[1] - tick_times[0], AUTO_C);
      check("auto_period_b", tick_times[2] - tick_times[1], AUTO_C);
    end
    push_adv();
    push_adv();
    key_step_n = 1'b0;
    repeat (8) @(negedge clk);
    key_step_n = 1'b1;
    wait_ticks(5, 40);
    if (tick_times.size() >= 5) begin
      check("nudge_delay", tick_times[3] - tick_times[2], 7);
      check("nudge_restart", tick_times[4] - tick_times[3], AUTO_C);
    end
    key_step_n = 1'b0;
    key_mode_n = 1'b0;
    repeat (8) @(negedge clk);
    key_step_n = 1'b1;
    key_mode_n = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    check("mode_wins_ticks", tick_times.size(), 5);
    check("manual_again", auto_mode, 0);
    check("page_kept", {word_index, hl_sw}, {2'(page_m / 2), 1'(page_m % 2)});
    check("auto_pending", exp_q.size(), 0);

    // Asynchronous reset while AUTO at page 5.
    tick_times.delete();
    push_adv();
    push_adv();
    push_adv();
    push_adv();
    press(8, 1'b0, 1'b1);
    wait_ticks(4, 80);
    check("pre_reset_page", {word_index, hl_sw}, {2'd2, 1'b1});
    check("pre_reset_auto", auto_mode, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check("areset_word_out", word_out, 0);
    check("areset_hl_sw", hl_sw, 0);
    check("areset_word_index", word_index, 0);
    check("areset_auto_mode", auto_mode, 0);
    check("areset_page_tick", page_tick, 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    page_m  = 0;
    tick_times.delete();
    repeat (25) @(negedge clk);
    #1;
    check("post_reset_idle", tick_times.size(), 0);
    check("post_reset_page", {word_index, hl_sw}, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
